uart_rx_framed: RTL

//  Parametrised oversampling UART receiver. Converts asynchronous serial_in into DATA_W-bit words.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_framed_if.sv | 22 ++
 rtl/uart_bit_sampler.sv | 54 +++++
 rtl/uart_rx_framed.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the framed UART receiver: parity selection and receiver FSM states.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE,
      PAR_EVEN,
      PAR_ODD
   } parity_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_framed_if.sv
// Word-delivery bus between the UART receiver (master) and the message decoder (slave).
interface uart_rx_framed_if #(
   parameter int DATA_W = 20
);
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic              data_ready;
   logic              frame_err;
   logic              parity_err;
   logic              overrun;
   logic              busy;

   modport master (
      output data, data_valid, frame_err, parity_err, overrun, busy,
      input  data_ready
   );

   modport slave (
      input  data, data_valid, frame_err, parity_err, overrun, busy,
      output data_ready
   );
endinterface

// File: rtl/uart_bit_sampler.sv
// Synchronises the serial line, detects transitions and generates the mid-bit sample strobe.
module uart_bit_sampler #(
   parameter int OVERSAMPLE = 10,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic serial_in,
   input  logic phase_clr,
   input  logic busy,
   output logic line_sync,
   output logic line_edge,
   output logic mid_tick
);

   localparam int CNT_W = $clog2(OVERSAMPLE);

   logic             sync_p0;
   logic             sync_p1;
   logic             line_p2;
   logic [CNT_W-1:0] phase;

   // Stage p0/p1: metastability synchroniser; p2: previous synchronised level for edge detect
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_p0 <= IDLE_LEVEL;
         sync_p1 <= IDLE_LEVEL;
         line_p2 <= IDLE_LEVEL;
      end else begin
         sync_p0 <= serial_in;
         sync_p1 <= sync_p0;
         line_p2 <= sync_p1;
      end
   end

   assign line_sync = sync_p1;
   assign line_edge = sync_p1 ^ line_p2;

   // Any transition inside a frame re-centres the sample point on the sender's clock
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase <= '0;
      end else if (phase_clr || (busy && line_edge)) begin
         phase <= '0;
      end else if (phase == CNT_W'(OVERSAMPLE - 1)) begin
         phase <= '0;
      end else begin
         phase <= phase + CNT_W'(1);
      end
   end

   assign mid_tick = (phase == CNT_W'(OVERSAMPLE / 2));

endmodule

// File: rtl/uart_rx_framed.sv
// Oversampling UART receiver: frames serial_in into DATA_W-bit words with parity/stop checks
// and a single-entry output slot on a valid/ready handshake.
module uart_rx_framed #(
   parameter int DATA_W     = 20,
   parameter int OVERSAMPLE = 10,
   parameter bit IDLE_LEVEL = 1'b0,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic serial_in,
   uart_rx_framed_if.master rx
);
   import uart_pkg::*;

   localparam int BIT_W = $clog2(DATA_W + 1);

   if (OVERSAMPLE < 4) begin : g_bad_oversample
      $error("uart_rx_framed: OVERSAMPLE must be >= 4");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_framed: STOP_BITS must be 1 or 2");
   end
   if (PARITY < 0 || PARITY > int'(PAR_ODD)) begin : g_bad_parity
      $error("uart_rx_framed: PARITY must be 0, 1 or 2");
   end

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] cur, input logic b);
      logic [DATA_W:0] wide;
      wide = {b, cur};
      return wide[DATA_W:1];
   endfunction

   rx_state_t         state, state_next;
   logic              line_sync, line_edge, mid_tick, phase_clr;
   logic              start_ok, shift_en, par_chk, stop_chk, done;
   logic [DATA_W-1:0] shift;
   logic [BIT_W-1:0]  bit_cnt;
   logic              stop_cnt;
   logic              par_bad, stop_bad;
   logic              par_expect, frame_final;
   logic [DATA_W-1:0] word;
   logic              word_valid, word_frame, word_par, ovr;

   uart_bit_sampler #(
      .OVERSAMPLE (OVERSAMPLE),
      .IDLE_LEVEL (IDLE_LEVEL)
   ) sampler (
      .clock     (clock),
      .reset     (reset),
      .serial_in (serial_in),
      .phase_clr (phase_clr),
      .busy      (state != IDLE),
      .line_sync (line_sync),
      .line_edge (line_edge),
      .mid_tick  (mid_tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      phase_clr  = 1'b0;
      start_ok   = 1'b0;
      shift_en   = 1'b0;
      par_chk    = 1'b0;
      stop_chk   = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (line_edge && (line_sync != IDLE_LEVEL)) begin
               state_next = START;
               phase_clr  = 1'b1;
            end
         end
         START: begin
            if (mid_tick) begin
               if (line_sync == IDLE_LEVEL) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
                  start_ok   = 1'b1;
               end
            end
         end
         DATA: begin
            if (mid_tick) begin
               shift_en = 1'b1;
               if (bit_cnt == BIT_W'(DATA_W - 1))
                  state_next = (PARITY != 0) ? uart_pkg::PARITY : STOP;
            end
         end
         uart_pkg::PARITY: begin
            if (mid_tick) begin
               par_chk    = 1'b1;
               state_next = STOP;
            end
         end
         STOP: begin
            if (mid_tick) begin
               stop_chk = 1'b1;
               if (stop_cnt == 1'(STOP_BITS - 1)) begin
                  state_next = IDLE;
                  done       = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign par_expect  = (PARITY == int'(PAR_ODD)) ? ~^shift : ^shift;
   assign frame_final = stop_bad | (line_sync != IDLE_LEVEL);

   always_ff @(posedge clock) begin
      if (start_ok) begin
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         par_bad  <= 1'b0;
         stop_bad <= 1'b0;
      end
      if (shift_en) begin
         shift   <= shift_in(shift, line_sync);
         bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (par_chk) par_bad <= (line_sync != par_expect);
      if (stop_chk) begin
         stop_bad <= frame_final;
         stop_cnt <= stop_cnt + 1'b1;
      end
   end

   // A completed frame only takes the slot if it is empty or being emptied this cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         word       <= '0;
         word_valid <= 1'b0;
         word_frame <= 1'b0;
         word_par   <= 1'b0;
         ovr        <= 1'b0;
      end else begin
         ovr <= 1'b0;
         if (done && (!word_valid || rx.data_ready)) begin
            word       <= shift;
            word_frame <= frame_final;
            word_par   <= par_bad;
            word_valid <= 1'b1;
         end else begin
            if (done) ovr <= 1'b1;
            if (word_valid && rx.data_ready) word_valid <= 1'b0;
         end
      end
   end

   assign rx.data       = word;
   assign rx.data_valid = word_valid;
   assign rx.frame_err  = word_frame;
   assign rx.parity_err = word_par;
   assign rx.overrun    = ovr;
   assign rx.busy       = (state != IDLE);

endmodule
